// File: rtl/bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl
// Description : Bus master / control sequencer for the shared 16-bit register
//               bus. It moves one word per request from a register (or an
//               immediate value) into a destination register. It drives the
//               one-hot enable/latch controls that each register consumes.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   start       in   transfer request, sampled only while idle
//   src_sel     in   [3:0] source register index, or IMM_SRC for immediate
//   dst_sel     in   [3:0] destination register index
//   imm_data    in   [15:0] immediate word
//   bus_in      in   [15:0] resolved bus value (snooped)
//   reg_enable  out  [NUM_REGS-1:0] one-hot register bus-drive enable
//   reg_latch   out  [NUM_REGS-1:0] one-hot register capture strobe
//   bus_out     out  [15:0] controller drive value (0 when not driving)
//   bus_drive   out  controller owns the bus (immediate transfers)
//   busy        out  transfer in progress
//   done        out  one-cycle completion pulse
//   error       out  one-cycle rejected-request pulse
//   captured    out  [15:0] last word seen on the bus during XFER
//   xfer_count  out  [7:0] completed transfers (wraps)
//
// Revision    : 1.0  initial release
// ============================================================================
module bus_transfer_ctrl #(
   parameter int NUM_REGS = 10,
   parameter int IMM_SRC  = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          src_sel,
   input  logic [3:0]          dst_sel,
   input  logic [15:0]         imm_data,
   input  logic [15:0]         bus_in,
   output logic [NUM_REGS-1:0] reg_enable,
   output logic [NUM_REGS-1:0] reg_latch,
   output logic [15:0]         bus_out,
   output logic                bus_drive,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [15:0]         captured,
   output logic [7:0]          xfer_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0]          c_NUM_REGS = 5'(NUM_REGS);
   localparam logic [3:0]          c_IMM_SRC  = 4'(IMM_SRC);
   localparam logic [NUM_REGS-1:0] c_ONE      = NUM_REGS'(1);

   logic [1:0]          state_q,    state_d;
   logic [3:0]          dst_q,      dst_d;
   logic [NUM_REGS-1:0] enable_q,   enable_d;
   logic [NUM_REGS-1:0] latch_q,    latch_d;
   logic [15:0]         bus_out_q,  bus_out_d;
   logic                drive_q,    drive_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                error_q,    error_d;
   logic [15:0]         captured_q, captured_d;
   logic [7:0]          count_q,    count_d;

   logic w_src_is_imm;
   logic w_req_valid;

   assign w_src_is_imm = (src_sel == c_IMM_SRC);
   assign w_req_valid  = ({1'b0, dst_sel} < c_NUM_REGS) &&
                         (({1'b0, src_sel} < c_NUM_REGS) || w_src_is_imm) &&
                         (src_sel != dst_sel);

   // Every output is a register; the next-state logic computes the value each
   // output must carry in the state being entered.
   always_comb begin
      state_d    = state_q;
      dst_d      = dst_q;
      enable_d   = '0;
      latch_d    = '0;
      bus_out_d  = 16'h0000;
      drive_d    = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      captured_d = captured_q;
      count_d    = count_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_req_valid) begin
                  state_d = S_SETUP;
                  dst_d   = dst_sel;
                  // The source drive decided here is held through XFER, so
                  // it doubles as the latched copy of src_sel / imm_data.
                  if (w_src_is_imm) begin
                     drive_d   = 1'b1;
                     bus_out_d = imm_data;
                  end else begin
                     enable_d = c_ONE << src_sel;
                  end
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_SETUP: begin
            state_d   = S_XFER;
            enable_d  = enable_q;
            drive_d   = drive_q;
            bus_out_d = bus_out_q;
            latch_d   = c_ONE << dst_q;
         end
         S_XFER: begin
            state_d    = S_DONE;
            captured_d = bus_in;
            done_d     = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            count_d = count_q + 8'd1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         dst_q      <= 4'd0;
         enable_q   <= '0;
         latch_q    <= '0;
         bus_out_q  <= 16'h0000;
         drive_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         captured_q <= 16'h0000;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         dst_q      <= dst_d;
         enable_q   <= enable_d;
         latch_q    <= latch_d;
         bus_out_q  <= bus_out_d;
         drive_q    <= drive_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         captured_q <= captured_d;
         count_q    <= count_d;
      end
   end

   assign reg_enable = enable_q;
   assign reg_latch  = latch_q;
   assign bus_out    = bus_out_q;
   assign bus_drive  = drive_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign captured   = captured_q;
   assign xfer_count = count_q;

`ifndef SYNTHESIS
   a_single_driver: assert property (@(posedge clk) disable iff (reset)
      ($countones(enable_q) + (drive_q ? 1 : 0)) <= 1);
   a_single_latch: assert property (@(posedge clk) disable iff (reset)
      $countones(latch_q) <= 1);
   a_latch_in_xfer: assert property (@(posedge clk) disable iff (reset)
      (latch_q != '0) |-> (state_q == S_XFER));
   a_latch_has_source: assert property (@(posedge clk) disable iff (reset)
      (latch_q != '0) |-> ((enable_q != '0) || drive_q));
   a_done_error_excl: assert property (@(posedge clk) disable iff (reset)
      !(done_q && error_q));
   a_bus_out_quiet: assert property (@(posedge clk) disable iff (reset)
      !drive_q |-> (bus_out_q == 16'h0000));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_ctrl
// Description : Self-checking bench for bus_transfer_ctrl. A behavioural
//               register file sits on the bus. A vector table, hand-written
//               corner sequences and a randomized run are checked against a
//               transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_transfer_ctrl;

   localparam int N  = 10;
   localparam int BW = 2 * N + 44;

   logic          clk;
   logic          reset;
   logic          start;
   logic [3:0]    src_sel;
   logic [3:0]    dst_sel;
   logic [15:0]   imm_data;
   logic [15:0]   bus_in;
   logic [N-1:0]  reg_enable;
   logic [N-1:0]  reg_latch;
   logic [15:0]   bus_out;
   logic          bus_drive;
   logic          busy;
   logic          done;
   logic          error;
   logic [15:0]   captured;
   logic [7:0]    xfer_count;

   int checks   = 0;
   int failures = 0;

   bus_transfer_ctrl #(.NUM_REGS(N), .IMM_SRC(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_sel    (src_sel),
      .dst_sel    (dst_sel),
      .imm_data   (imm_data),
      .bus_in     (bus_in),
      .reg_enable (reg_enable),
      .reg_latch  (reg_latch),
      .bus_out    (bus_out),
      .bus_drive  (bus_drive),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .captured   (captured),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- environment: register file on the bus ----------------
   function automatic logic [15:0] init_val(input int i);
      return (i == 2) ? 16'hA5A5 : 16'(16'h1000 + i);
   endfunction

   logic [15:0] regs [N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset)             regs[i] <= init_val(i);
         else if (reg_latch[i]) regs[i] <= bus_in;
      end
   end

   always_comb begin
      bus_in = 16'h0000;
      if (bus_drive) bus_in = bus_out;
      else begin
         for (int i = 0; i < N; i++)
            if (reg_enable[i]) bus_in = regs[i];
      end
   end

   // ---------------- helpers ----------------
   logic [BW-1:0] act_b;
   assign act_b = {reg_enable, reg_latch, bus_out, bus_drive, busy, done, error,
                   captured, xfer_count};

   function automatic logic [BW-1:0] mk(input logic [N-1:0] en, input logic [N-1:0] lat,
                                        input logic [15:0] bo, input logic drv,
                                        input logic bsy, input logic dn, input logic er,
                                        input logic [15:0] cap, input logic [7:0] cnt);
      return {en, lat, bo, drv, bsy, dn, er, cap, cnt};
   endfunction

   function automatic logic [N-1:0] onehot(input logic [3:0] k);
      logic [N-1:0] one;
      one = N'(1);
      return (int'(k) < N) ? (one << k) : '0;
   endfunction

   function automatic bit req_valid(input logic [3:0] s, input logic [3:0] d);
      return (int'(d) < N) && ((int'(s) < N) || (s == 4'd15)) && (s != d);
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [3:0]  src;
      logic [3:0]  dst;
      logic [15:0] imm;
      bit          valid;
      logic [15:0] word;
   } vec_t;

   logic [15:0] exp_capt;
   logic [7:0]  exp_cnt;

   task automatic drive_noise();
      start    = 1'b1;
      src_sel  = 4'($urandom_range(0, 15));
      dst_sel  = 4'($urandom_range(0, 15));
      imm_data = 16'($urandom);
   endtask

   task automatic apply_vec(input vec_t v, input bit noise, input string tag);
      logic [N-1:0] en;
      logic         drv;
      logic [15:0]  bo;
      drv = (v.src == 4'd15);
      en  = drv ? '0 : onehot(v.src);
      bo  = drv ? v.imm : 16'h0000;
      start = 1'b1; src_sel = v.src; dst_sel = v.dst; imm_data = v.imm;
      @(negedge clk);
      if (!v.valid) begin
         check({tag, "_err"}, act_b, mk('0, '0, 16'h0, 0, 0, 0, 1, exp_capt, exp_cnt));
         start = 1'b0;
         @(negedge clk);
         check({tag, "_err_end"}, act_b, mk('0, '0, 16'h0, 0, 0, 0, 0, exp_capt, exp_cnt));
      end else begin
         if (noise) drive_noise(); else start = 1'b0;
         check({tag, "_setup"}, act_b, mk(en, '0, bo, drv, 1, 0, 0, exp_capt, exp_cnt));
         @(negedge clk);
         if (noise) drive_noise();
         check({tag, "_xfer"}, act_b, mk(en, onehot(v.dst), bo, drv, 1, 0, 0, exp_capt, exp_cnt));
         @(negedge clk);
         if (noise) drive_noise();
         exp_capt = v.word;
         check({tag, "_done"}, act_b, mk('0, '0, 16'h0, 0, 1, 1, 0, exp_capt, exp_cnt));
         @(negedge clk);
         start = 1'b0;
         exp_cnt = exp_cnt + 8'd1;
         check({tag, "_idle"}, act_b, mk('0, '0, 16'h0, 0, 0, 0, 0, exp_capt, exp_cnt));
         check({tag, "_dst_reg"}, BW'(regs[v.dst]), BW'(v.word));
      end
   endtask

   vec_t tbl [14] = '{
      '{4'd15, 4'd3,  16'h5500, 1'b1, 16'h5500},
      '{4'd2,  4'd7,  16'h0000, 1'b1, 16'hA5A5},
      '{4'd4,  4'd4,  16'h0000, 1'b0, 16'h0000},
      '{4'd0,  4'd12, 16'h0000, 1'b0, 16'h0000},
      '{4'd11, 4'd0,  16'h0000, 1'b0, 16'h0000},
      '{4'd3,  4'd9,  16'h0000, 1'b1, 16'h5500},
      '{4'd7,  4'd0,  16'h0000, 1'b1, 16'hA5A5},
      '{4'd15, 4'd9,  16'hFFFF, 1'b1, 16'hFFFF},
      '{4'd10, 4'd1,  16'h0000, 1'b0, 16'h0000},
      '{4'd1,  4'd15, 16'h0000, 1'b0, 16'h0000},
      '{4'd15, 4'd15, 16'h1234, 1'b0, 16'h0000},
      '{4'd9,  4'd2,  16'h0000, 1'b1, 16'hFFFF},
      '{4'd8,  4'd1,  16'h0000, 1'b1, 16'h1008},
      '{4'd15, 4'd0,  16'h0000, 1'b1, 16'h0000}
   };

   // ---------------- transaction-level reference model ----------------
   logic [BW-1:0] q [$];
   logic [BW-1:0] cur;
   logic [15:0]   mregs [N];
   logic [15:0]   mcapt;
   logic [7:0]    mcnt;

   function automatic logic [BW-1:0] idle_rec();
      return mk('0, '0, 16'h0, 0, 0, 0, 0, mcapt, mcnt);
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < N; i++) mregs[i] = init_val(i);
      mcapt = 16'h0000;
      mcnt  = 8'd0;
      cur   = idle_rec();
   endtask

   // Called with the inputs present at the coming clock edge; leaves in 'cur'
   // the outputs expected for the cycle after that edge.
   task automatic model_step();
      logic [15:0]  word;
      logic [N-1:0] en;
      logic         drv;
      if (reset) begin
         model_reset();
         return;
      end
      if (!cur[26] && start) begin
         if (req_valid(src_sel, dst_sel)) begin
            drv  = (src_sel == 4'd15);
            word = drv ? imm_data : mregs[src_sel];
            en   = drv ? '0 : onehot(src_sel);
            q.push_back(mk(en, '0, drv ? imm_data : 16'h0, drv, 1, 0, 0, mcapt, mcnt));
            q.push_back(mk(en, onehot(dst_sel), drv ? imm_data : 16'h0, drv, 1, 0, 0, mcapt, mcnt));
            q.push_back(mk('0, '0, 16'h0, 0, 1, 1, 0, word, mcnt));
            mregs[dst_sel] = word;
            mcapt = word;
            mcnt  = mcnt + 8'd1;
         end else begin
            q.push_back(mk('0, '0, 16'h0, 0, 0, 0, 1, mcapt, mcnt));
         end
      end
      cur = (q.size() > 0) ? q.pop_front() : idle_rec();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int  ndone, bad, errs, last, cyc;
      bit  finished;

      reset = 1'b1; start = 1'b0; src_sel = 4'd0; dst_sel = 4'd0; imm_data = 16'h0;
      exp_capt = 16'h0; exp_cnt = 8'd0;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", act_b, '0);
      reset = 1'b0;

      // table-driven single requests
      for (int i = 0; i < 14; i++) apply_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

      // new requests while busy are ignored, no error
      apply_vec('{4'd1, 4'd5, 16'h0000, 1'b1, 16'h1008}, 1'b1, "busy_ignore");

      // reset while in XFER
      start = 1'b1; src_sel = 4'd15; dst_sel = 4'd4; imm_data = 16'h1234;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst_xfer_latch", act_b, mk('0, onehot(4'd4), 16'h1234, 1, 1, 0, 0, exp_capt, exp_cnt));
      reset = 1'b1;
      @(negedge clk);
      check("rst_xfer_clear", act_b, '0);
      reset = 1'b0;
      exp_capt = 16'h0; exp_cnt = 8'd0;
      apply_vec('{4'd2, 4'd6, 16'h0000, 1'b1, 16'hA5A5}, 1'b0, "post_rst");

      // 256 back-to-back immediate transfers with start held high
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b1; src_sel = 4'd15; dst_sel = 4'd5; imm_data = 16'h0100;
      ndone = 0; bad = 0; errs = 0; last = -1; finished = 1'b0;
      for (cyc = 0; cyc < 1100 && !finished; cyc++) begin
         @(negedge clk);
         if (error) errs++;
         if (done) begin
            ndone++;
            if (last >= 0 && cyc - last != 4) bad++;
            last = cyc;
            if (ndone == 256) begin
               check("b2b_count_255", BW'(xfer_count), BW'(8'd255));
               start = 1'b0;
               @(negedge clk);
               check("b2b_count_wrap", BW'(xfer_count), BW'(8'd0));
               finished = 1'b1;
            end
         end
      end
      check("b2b_done_total", BW'(ndone), BW'(256));
      check("b2b_spacing_bad", BW'(bad), BW'(0));
      check("b2b_errors", BW'(errs), BW'(0));

      // randomized run against the reference model
      reset = 1'b1; start = 1'b0;
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         check($sformatf("rand_c%0d", c), act_b, cur);
         if (c < 1490) begin
            reset    = ($urandom_range(0, 63) == 0);
            start    = 1'($urandom_range(0, 1));
            src_sel  = 4'($urandom_range(0, 15));
            dst_sel  = 4'($urandom_range(0, 15));
            imm_data = 16'($urandom);
         end else begin
            reset = 1'b0;
            start = 1'b0;
         end
         model_step();
      end
      for (int i = 0; i < N; i++)
         check($sformatf("rand_reg%0d", i), BW'(regs[i]), BW'(mregs[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/bus_transfer_ctrl.md
Name: bus_transfer_ctrl

Overview:
Bus master / control sequencer for the shared 16-bit register bus. On a start request it moves one word onto the bus and into a target register. The source is either a register file member or an immediate value. It generates the one-hot enable (bus drive) and latch (capture) controls that each register instance consumes. It is the initiator side of the register latch/enable interface and replaces ad-hoc button-driven bus stimulus.

Parameters:
NUM_REGS, 10, number of attached registers; index 0..NUM_REGS-1 (max 15).
IMM_SRC, 15, src_sel code selecting imm_data as bus source.

Ports:
clk  input  1  system clock (one-shot pulser output in board builds)
reset  input  1  synchronous, active-high reset
start  input  1  request a transfer; sampled only in IDLE
src_sel  input  4  source register index, or IMM_SRC for immediate
dst_sel  input  4  destination register index
imm_data  input  16  immediate word, used when src_sel==IMM_SRC
bus_in  input  16  resolved bus value (snoop)
reg_enable  output  NUM_REGS  one-hot: selected register drives bus
reg_latch  output  NUM_REGS  one-hot: selected register captures bus on next clk
bus_out  output  16  controller's drive value (top-level tri-states on bus_drive)
bus_drive  output  1  controller owns bus (immediate transfers)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, transfer complete
error  output  1  one-cycle pulse, request rejected
captured  output  16  last word seen on bus during XFER
xfer_count  output  8  completed transfers, wraps

Behaviour:
- Reset (sync, any state incl. mid-transfer): state=IDLE; reg_enable=0, reg_latch=0, bus_drive=0, bus_out=0, busy=0, done=0, error=0, captured=0, xfer_count=0. No partial latch is ever issued after a reset edge.
- States: IDLE, SETUP, XFER, DONE.
- IDLE, start=1, request valid: register src_sel/dst_sel/imm_data internally; go to SETUP. Later input changes are ignored until return to IDLE.
- Valid request: dst_sel<NUM_REGS, AND (src_sel<NUM_REGS or src_sel==IMM_SRC), AND src_sel!=dst_sel.
- IDLE, start=1, request invalid: stay IDLE; error=1 for exactly the next cycle; no control output asserts; xfer_count unchanged.
- SETUP (1 cycle): drive the source.
  - Register source: reg_enable[src]=1.
  - Immediate source: bus_drive=1 and bus_out=latched imm.
  - reg_latch=0 (bus settle cycle). Next state XFER.
- XFER (1 cycle): same source drive held; reg_latch[dst]=1; captured<=bus_in at end of cycle. Next state DONE.
- DONE (1 cycle): all enables, latches and bus_drive=0; done=1; xfer_count<=xfer_count+1 (255->0); next state IDLE.
- Latency: start accepted at edge N; SETUP in cycle N+1, XFER in cycle N+2, done high in cycle N+3, IDLE at N+4. Back-to-back start is accepted when held in IDLE after DONE, giving 4 cycles per transfer.
- start while busy: ignored, no error, no queueing.
- Invariants, checked by assertion:
  - popcount(reg_enable)+bus_drive <= 1.
  - popcount(reg_latch) <= 1.
  - reg_latch nonzero only in XFER.
  - The source drive is never released in the same cycle as the latch.
  - done and error are never high together.
- bus_out holds 0 whenever bus_drive=0.
- All outputs are registered, and every output changes only on clk.

Test Plan:
1. reset=1 for 2 cycles, then start with src=IMM_SRC, dst=3, imm=16'h5500 -> SETUP: bus_drive=1, bus_out=5500, reg_latch=0. XFER: reg_latch=10'b0000001000. DONE: done=1. captured=5500, xfer_count=1.
2. Register-to-register, src=2, dst=7, bus_in model returns 16'hA5A5 when reg_enable[2] -> reg_enable=10'b0000000100 for exactly 2 cycles. reg_latch[7] is high only in the 2nd of those. captured=A5A5.
3. Invalid requests, each from IDLE: src=4 dst=4; dst=12; src=11 -> error pulse 1 cycle per request, busy stays 0, all controls 0, xfer_count unchanged.
4. Assert start with new selects during SETUP/XFER/DONE of an active transfer -> ignored. The original transfer completes unchanged and no error is raised.
5. reset asserted during XFER -> next cycle: all outputs 0, state IDLE, captured=0. A following valid start completes normally.
6. 256 back-to-back immediate transfers with start held high -> done every 4th cycle; xfer_count goes 255->0 on the 256th transfer.
